// File: rtl/mm_pkg.sv
// mm_pkg -- shared definitions for the mastermind guess scorer.
//   Code geometry : NUM_PEGS pegs of COLOR_W bits each (CODE_W total),
//                   NUM_COLORS distinct colour values.
//   Encodings     : result to the turn counter (RES_*), game_over from the
//                   turn counter (GO_*), and the scorer FSM state type.
package mm_pkg;

  localparam int NUM_PEGS   = 4;
  localparam int COLOR_W    = 3;
  localparam int NUM_COLORS = 8;
  localparam int CODE_W     = NUM_PEGS * COLOR_W;

  localparam logic [1:0] RES_NONE = 2'b00;
  localparam logic [1:0] RES_NEXT = 2'b01;
  localparam logic [1:0] RES_WIN  = 2'b10;

  localparam logic [1:0] GO_PLAYING = 2'd0;
  localparam logic [1:0] GO_LOST    = 2'd1;
  localparam logic [1:0] GO_WON     = 2'd2;

  typedef enum logic [1:0] {
    IDLE,
    EXACT,
    COLOR,
    REPORT
  } state_t;

  // Smaller of two per-colour occurrence counts.
  function automatic logic [2:0] min3(input logic [2:0] a, input logic [2:0] b);
    return (a < b) ? a : b;
  endfunction

endpackage

// File: rtl/peg_color_count.sv
// peg_color_count -- combinational count of how many pegs of a code carry
// a given colour.
//   code  : in,  CODE_W bits, NUM_PEGS packed pegs (peg0 in the LSBs)
//   color : in,  COLOR_W bits, colour value to look for
//   count : out, 3 bits, number of matching pegs (0..4)
module peg_color_count
  import mm_pkg::*;
(
  input  logic [CODE_W-1:0]  code,
  input  logic [COLOR_W-1:0] color,
  output logic [2:0]         count
);

  always_comb begin
    count = '0;
    for (int p = 0; p < NUM_PEGS; p++) begin
      if (code[p*COLOR_W +: COLOR_W] == color) begin
        count = count + 3'd1;
      end
    end
  end

endmodule

// File: rtl/guess_scorer.sv
// guess_scorer -- sequential mastermind scorer. A submit in IDLE while the
// game is still playing latches guess and secret, counts exact matches one
// peg per cycle, optionally counts colour matches one colour per cycle, and
// then reports for a single cycle.
//   clk, reset : clock and synchronous active-high reset
//   submit     : in,  one-cycle scoring request (only accepted in IDLE)
//   guess      : in,  12 bits, pegs 3..0 in [11:9]..[2:0]
//   secret     : in,  12 bits, hidden code, same layout
//   game_over  : in,  2 bits, 0 playing / 1 lost / 2 won
//   busy       : out, high while a score is in progress (EXACT..REPORT)
//   black      : out, 3 bits, exact matches, held until the next report
//   white      : out, 3 bits, right colour wrong place, held likewise
//   result     : out, 2 bits, RES_WIN / RES_NEXT during REPORT, else RES_NONE
//   valid      : out, one-cycle strobe during REPORT
// Configuration: define GUESS_SCORER_WHITE_PEG_EN to include the COLOR pass
// and white computation (13-cycle latency); without it white is tied to 0
// and EXACT goes straight to REPORT (5-cycle latency).
module guess_scorer
  import mm_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              submit,
  input  logic [CODE_W-1:0] guess,
  input  logic [CODE_W-1:0] secret,
  input  logic [1:0]        game_over,
  output logic              busy,
  output logic [2:0]        black,
  output logic [2:0]        white,
  output logic [1:0]        result,
  output logic              valid
);

  state_t            state, state_next;
  logic [CODE_W-1:0] guess_q, secret_q;
  logic [1:0]        idx;
  logic [2:0]        black_acc, black_next;
  logic              peg_eq, start, last_peg;

  assign start      = (state == IDLE) && submit && (game_over == GO_PLAYING);
  assign last_peg   = (idx == 2'(NUM_PEGS - 1));
  assign peg_eq     = (guess_q[idx*COLOR_W +: COLOR_W] == secret_q[idx*COLOR_W +: COLOR_W]);
  // Includes the peg being compared this cycle, so the final count is
  // available on the edge that leaves EXACT.
  assign black_next = black_acc + {2'b00, peg_eq};
  assign busy       = (state != IDLE);

`ifdef GUESS_SCORER_WHITE_PEG_EN
  logic [COLOR_W-1:0] color;
  logic [2:0]         guess_cnt, secret_cnt;
  logic [3:0]         match_acc, match_next;
  logic [3:0]         white_full;
  logic               last_color;

  peg_color_count u_guess_cnt (.code(guess_q),  .color(color), .count(guess_cnt));
  peg_color_count u_secret_cnt(.code(secret_q), .color(color), .count(secret_cnt));

  assign last_color = (color == COLOR_W'(NUM_COLORS - 1));
  assign match_next = match_acc + {1'b0, min3(guess_cnt, secret_cnt)};
  // Every exact match is also a colour match, so this never underflows.
  assign white_full = match_next - {1'b0, black_acc};
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next state plus the REPORT strobe and result code.
  always_comb begin
    state_next = state;
    valid      = 1'b0;
    result     = RES_NONE;
    case (state)
      IDLE:   if (start) state_next = EXACT;
`ifdef GUESS_SCORER_WHITE_PEG_EN
      EXACT:  if (last_peg) state_next = COLOR;
      COLOR:  if (last_color) state_next = REPORT;
`else
      EXACT:  if (last_peg) state_next = REPORT;
`endif
      REPORT: begin
        state_next = IDLE;
        valid      = 1'b1;
        result     = (black == 3'(NUM_PEGS)) ? RES_WIN : RES_NEXT;
      end
      default: state_next = IDLE;
    endcase
  end

  // Datapath: operand latch, accumulators and the held black/white outputs,
  // which are loaded on the edge entering REPORT so they line up with valid.
  always_ff @(posedge clk) begin
    if (reset) begin
      guess_q   <= '0;
      secret_q  <= '0;
      idx       <= '0;
      black_acc <= '0;
      black     <= '0;
`ifdef GUESS_SCORER_WHITE_PEG_EN
      color     <= '0;
      match_acc <= '0;
      white     <= '0;
`endif
    end else begin
      case (state)
        IDLE: if (start) begin
          guess_q   <= guess;
          secret_q  <= secret;
          idx       <= '0;
          black_acc <= '0;
`ifdef GUESS_SCORER_WHITE_PEG_EN
          color     <= '0;
          match_acc <= '0;
`endif
        end
        EXACT: begin
          black_acc <= black_next;
          idx       <= idx + 2'd1;
`ifndef GUESS_SCORER_WHITE_PEG_EN
          if (last_peg) black <= black_next;
`endif
        end
`ifdef GUESS_SCORER_WHITE_PEG_EN
        COLOR: begin
          match_acc <= match_next;
          color     <= color + COLOR_W'(1);
          if (last_color) begin
            black <= black_acc;
            white <= white_full[2:0];
          end
        end
`endif
        default: ;
      endcase
    end
  end

`ifndef GUESS_SCORER_WHITE_PEG_EN
  assign white = '0;
`endif

endmodule

// File: tb/tb_guess_scorer.sv
// tb_guess_scorer -- self-checking bench for guess_scorer. A behavioural
// model scores each accepted submit with plain colour histograms and a
// cycle countdown; a compare process checks every output on every falling
// edge. Directed cases pin the model with literal expectations, then a
// randomized phase mixes submits, game_over changes, input churn and resets.
`timescale 1ns/1ps
module tb_guess_scorer;
  import mm_pkg::*;

`ifdef GUESS_SCORER_WHITE_PEG_EN
  localparam int LAT      = 13;
  localparam bit WHITE_ON = 1'b1;
`else
  localparam int LAT      = 5;
  localparam bit WHITE_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        submit = 1'b0;
  logic [11:0] guess = '0;
  logic [11:0] secret = '0;
  logic [1:0]  game_over = '0;
  logic        busy, valid;
  logic [2:0]  black, white;
  logic [1:0]  result;

  int checks = 0;
  int errors = 0;
  int pulses = 0;
  bit compare_en = 1'b0;

  always #5 clk = ~clk;

  guess_scorer dut (
    .clk(clk), .reset(reset), .submit(submit), .guess(guess), .secret(secret),
    .game_over(game_over), .busy(busy), .black(black), .white(white),
    .result(result), .valid(valid)
  );

  // Scores a guess from colour histograms: black = same peg in same place,
  // white = sum over colours of min(histograms) minus black.
  function automatic void scoreModel(input logic [11:0] g, input logic [11:0] s,
                                     output int b, output int w);
    int gc[8];
    int sc[8];
    int total;
    b = 0;
    total = 0;
    for (int i = 0; i < 8; i++) begin gc[i] = 0; sc[i] = 0; end
    for (int p = 0; p < 4; p++) begin
      int gp;
      int sp;
      gp = int'(g[3*p +: 3]);
      sp = int'(s[3*p +: 3]);
      if (gp == sp) b++;
      gc[gp]++;
      sc[sp]++;
    end
    for (int i = 0; i < 8; i++) total += (gc[i] < sc[i]) ? gc[i] : sc[i];
    w = WHITE_ON ? total - b : 0;
  endfunction

  // Model: which clock period of a score we are in, and what it reports.
  bit m_pending = 1'b0;
  int m_cycle = 0;
  int m_b = 0, m_w = 0;
  bit exp_valid = 1'b0;
  int exp_black = 0, exp_white = 0;

  always @(posedge clk) begin
    if (reset) begin
      m_pending = 1'b0;
      exp_valid = 1'b0;
      exp_black = 0;
      exp_white = 0;
    end else if (m_pending) begin
      m_cycle++;
      if (m_cycle == LAT) begin
        exp_valid = 1'b1;
        exp_black = m_b;
        exp_white = m_w;
      end else if (m_cycle > LAT) begin
        m_pending = 1'b0;
        exp_valid = 1'b0;
      end
    end else if (submit && game_over == 2'd0) begin
      scoreModel(guess, secret, m_b, m_w);
      m_pending = 1'b1;
      m_cycle = 1;
    end
  end

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Every-cycle comparison against the model.
  always @(negedge clk) begin
    if (compare_en) begin
      checkOutput("busy",   int'(busy),   int'(m_pending));
      checkOutput("valid",  int'(valid),  int'(exp_valid));
      checkOutput("result", int'(result),
                  exp_valid ? ((exp_black == 4) ? 2 : 1) : 0);
      checkOutput("black",  int'(black),  exp_black);
      checkOutput("white",  int'(white),  exp_white);
    end
    if (valid === 1'b1) pulses++;
  end

  task automatic applyStimulus(input bit sub, input logic [11:0] g, input logic [11:0] s,
                               input logic [1:0] go, input bit rst);
    @(negedge clk);
    submit    = sub;
    guess     = g;
    secret    = s;
    game_over = go;
    reset     = rst;
  endtask

  function automatic logic [11:0] code4(input int a, input int b, input int c, input int d);
    return {3'(a), 3'(b), 3'(c), 3'(d)};
  endfunction

  // Submit once, measure the cycles until valid and check the literal score.
  task automatic runDirected(input string name, input logic [11:0] g, input logic [11:0] s,
                             input int eb, input int ew, input int er);
    int n;
    bit seen;
    applyStimulus(1'b1, g, s, 2'd0, 1'b0);
    n = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      submit = 1'b0;
      guess  = ~g;
      if (valid === 1'b1) seen = 1'b1;
    end
    checkOutput({name, "_latency"}, seen ? n : -1, LAT);
    checkOutput({name, "_black"}, int'(black), eb);
    checkOutput({name, "_white"}, int'(white), ew);
    checkOutput({name, "_result"}, int'(result), er);
    repeat (2) applyStimulus(1'b0, g, s, 2'd0, 1'b0);
  endtask

  initial begin
    int b, w, p0, rst_at;
    logic [11:0] g, s;

    // Literal pins on the model itself.
    scoreModel(code4(1,2,3,4), code4(1,2,3,4), b, w);
    checkOutput("model_win_black", b, 4);
    checkOutput("model_win_white", w, 0);
    scoreModel(code4(4,3,2,1), code4(1,2,3,4), b, w);
    checkOutput("model_rev_black", b, 0);
    checkOutput("model_rev_white", w, WHITE_ON ? 4 : 0);
    scoreModel(code4(1,2,1,0), code4(1,1,2,2), b, w);
    checkOutput("model_mix_black", b, 1);
    checkOutput("model_mix_white", w, WHITE_ON ? 2 : 0);

    // Reset state.
    repeat (2) applyStimulus(1'b1, '0, '0, 2'd0, 1'b1);
    compare_en = 1'b1;
    applyStimulus(1'b0, '0, '0, 2'd0, 1'b0);
    checkOutput("reset_busy", int'(busy), 0);
    checkOutput("reset_black", int'(black), 0);

    runDirected("win",  code4(1,2,3,4), code4(1,2,3,4), 4, 0, 2);
    runDirected("rev",  code4(4,3,2,1), code4(1,2,3,4), 0, WHITE_ON ? 4 : 0, 1);
    runDirected("mix",  code4(1,2,1,0), code4(1,1,2,2), 1, WHITE_ON ? 2 : 0, 1);

    // Repeated submits while busy and during REPORT: one pulse only.
    p0 = pulses;
    applyStimulus(1'b1, code4(5,5,0,1), code4(1,5,0,5), 2'd0, 1'b0);
    for (int k = 1; k <= LAT + 4; k++)
      applyStimulus((k == 3 || k == LAT - 1 || k == LAT), code4(k % 8,2,3,4),
                    code4(1,2,3,4), 2'd0, 1'b0);
    checkOutput("busy_submit_pulses", pulses - p0, 1);

    // Reset mid-score: no pulse, everything back to zero.
    p0 = pulses;
    rst_at = (LAT - 2 < 6) ? LAT - 2 : 6;
    applyStimulus(1'b1, code4(1,2,3,4), code4(1,2,3,4), 2'd0, 1'b0);
    for (int k = 1; k <= LAT + 4; k++)
      applyStimulus(1'b0, code4(1,2,3,4), code4(1,2,3,4), 2'd0, (k == rst_at));
    checkOutput("reset_mid_pulses", pulses - p0, 0);
    checkOutput("reset_mid_busy", int'(busy), 0);

    // game_over blocks a submit; playing again allows it.
    p0 = pulses;
    applyStimulus(1'b1, code4(1,2,3,4), code4(1,2,3,4), 2'd2, 1'b0);
    applyStimulus(1'b0, code4(1,2,3,4), code4(1,2,3,4), 2'd2, 1'b0);
    checkOutput("over_busy", int'(busy), 0);
    repeat (LAT + 2) applyStimulus(1'b0, '0, '0, 2'd2, 1'b0);
    checkOutput("over_pulses", pulses - p0, 0);
    runDirected("replay", code4(7,0,7,0), code4(0,7,0,7), 0, WHITE_ON ? 4 : 0, 1);

    // Randomized traffic checked every cycle by the model.
    g = '0;
    s = '0;
    for (int i = 0; i < 600; i++) begin
      logic [1:0] go;
      if ($urandom_range(0, 15) == 0) s = 12'($urandom);
      if ($urandom_range(0, 1) == 0) s = code4($urandom_range(0,3), $urandom_range(0,3),
                                               $urandom_range(0,3), $urandom_range(0,3));
      g = ($urandom_range(0, 3) == 0) ? s : code4($urandom_range(0,3), $urandom_range(0,7),
                                                  $urandom_range(0,3), $urandom_range(0,3));
      go = ($urandom_range(0, 7) == 0) ? 2'($urandom_range(1, 2)) : 2'd0;
      applyStimulus($urandom_range(0, 3) == 0, g, s, go, $urandom_range(0, 79) == 0);
    end
    repeat (LAT + 2) applyStimulus(1'b0, g, s, 2'd0, 1'b0);

    compare_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
